combo_input_sequencer: RTL and testbench



---
 rtl/combo_input_sequencer.sv | 139 +++++++++++++
 tb/tb_combo_input_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_input_sequencer.sv
// combo_input_sequencer
//   Plays a latched list of button codes as one-hot single-button pulses.
//   Each press is spaced so that it lands inside the previous press's combo
//   window. Drives the combo-window inputs on behalf of the CPU opponent and
//   demo mode.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      begin playback of seq_codes/seq_len (only honoured when idle)
//   abort      stop playback at once, no done pulse
//   seq_len    number of steps, clamped to MAX_STEPS
//   seq_codes  step i code in bits [3i+2:3i]
//   btn_pulse  registered one-hot press output (or zero)
//   busy       high from the first press through the done cycle
//   done       one-cycle pulse after the final press
//   step_idx   current step index, 0 when idle
module combo_input_sequencer #(
   parameter int NUM_BUTTONS  = 5,
   parameter int MAX_STEPS    = 4,
   parameter int STEP_GAP     = 12500000,
   parameter int PULSE_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [2:0]             seq_len,
   input  logic [3*MAX_STEPS-1:0] seq_codes,
   output logic [NUM_BUTTONS-1:0] btn_pulse,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             step_idx
);

   localparam int CNT_W = $clog2(STEP_GAP + 1);
   // Terminal counts: a press lasts PULSE_CYCLES, the gap fills the rest of STEP_GAP.
   localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STEP_GAP - PULSE_CYCLES - 1);
   localparam logic [2:0]       MAX_LEN    = 3'(MAX_STEPS);
   localparam logic [3:0]       NB         = 4'(NUM_BUTTONS);

   typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_DONE} state_t;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [2:0]             step, step_n;
   logic [2:0]             len, len_n;
   logic [2:0]             len_clamp;
   logic [3*MAX_STEPS-1:0] codes, codes_n;
   logic [NUM_BUTTONS-1:0] pulse_n;

   // Codes at or above NUM_BUTTONS are rest steps: same timing, no pulse.
   function automatic logic [NUM_BUTTONS-1:0] press_vec(
      input logic [3*MAX_STEPS-1:0] c,
      input logic [2:0]             idx
   );
      logic [2:0] code;
      code = c[3*idx +: 3];
      if ({1'b0, code} < NB) return NUM_BUTTONS'(1) << code;
      return '0;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         step      <= '0;
         len       <= '0;
         codes     <= '0;
         btn_pulse <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         step      <= step_n;
         len       <= len_n;
         codes     <= codes_n;
         btn_pulse <= pulse_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      step_n    = step;
      len_n     = len;
      codes_n   = codes;
      len_clamp = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;

      case (state)
         S_IDLE: begin
            // abort beats a simultaneous start; zero-length requests are ignored
            if (start && !abort && len_clamp != 3'd0) begin
               state_n = S_PRESS;
               cnt_n   = '0;
               step_n  = '0;
               len_n   = len_clamp;
               codes_n = seq_codes;
            end
         end
         S_PRESS: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (cnt == PRESS_LAST) begin
               cnt_n   = '0;
               state_n = (step == len - 3'd1) ? S_DONE : S_GAP;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (cnt == GAP_LAST) begin
               state_n = S_PRESS;
               cnt_n   = '0;
               step_n  = step + 3'd1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      if (state_n == S_IDLE) begin
         cnt_n  = '0;
         step_n = '0;
      end

      // Pulse is computed from next-state values so btn_pulse is a plain register.
      pulse_n = (state_n == S_PRESS) ? press_vec(codes_n, step_n) : '0;
   end

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign step_idx = step;

endmodule

// File: tb/tb_combo_input_sequencer.sv
// Testbench for combo_input_sequencer (NUM_BUTTONS=5, MAX_STEPS=4, STEP_GAP=8,
// PULSE_CYCLES=2). A timing model derived from the press schedule pushes the
// expected outputs for every cycle; a monitor pops and compares them.
module tb_combo_input_sequencer;
  localparam int NB = 5;
  localparam int MS = 4;
  localparam int G  = 8;
  localparam int P  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  seq_len = 3'd0;
  logic [11:0] seq_codes = 12'd0;
  logic [4:0]  btn_pulse;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;

  combo_input_sequencer #(
    .NUM_BUTTONS (NB),
    .MAX_STEPS   (MS),
    .STEP_GAP    (G),
    .PULSE_CYCLES(P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .seq_len  (seq_len),
    .seq_codes(seq_codes),
    .btn_pulse(btn_pulse),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] pulse;
    logic       busy;
    logic       done;
    logic [2:0] step;
  } out_t;

  out_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: a sequence accepted at edge t0 occupies cycles
  // 1 .. 1+(L-1)*G+P after it; press k covers cycles 1+k*G .. k*G+P.
  int ecnt     = 0;
  bit m_active = 1'b0;
  int m_t0     = 0;
  int m_len    = 0;
  int m_code[4];

  initial begin
    forever begin : model
      int   n, k, off, L, dcyc;
      out_t e;
      @(posedge clk);
      ecnt++;
      if (reset) begin
        m_active = 1'b0;
      end else if (m_active) begin
        dcyc = 1 + (m_len - 1) * G + P;
        if (abort || (ecnt - m_t0) >= dcyc) m_active = 1'b0;
      end else if (start && !abort) begin
        L = (int'(seq_len) > MS) ? MS : int'(seq_len);
        if (L != 0) begin
          m_active = 1'b1;
          m_t0     = ecnt;
          m_len    = L;
          for (int i = 0; i < 4; i++) m_code[i] = int'(seq_codes[3*i +: 3]);
        end
      end
      e = '0;
      if (m_active) begin
        n      = ecnt - m_t0 + 1;
        k      = (n - 1) / G;
        off    = (n - 1) % G;
        dcyc   = 1 + (m_len - 1) * G + P;
        e.busy = 1'b1;
        e.step = 3'((k < m_len) ? k : m_len - 1);
        e.done = (n == dcyc);
        if (k < m_len && off < P && m_code[k] < NB) e.pulse = 5'(1) << m_code[k];
      end
      exp_q.push_back(e);
    end
  end

  initial begin
    forever begin : monitor
      out_t a, e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {btn_pulse, busy, done, step_idx};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL outputs @%0t: got pulse=%b busy=%b done=%b step=%0d, want pulse=%b busy=%b done=%b step=%0d",
                   $time, a.pulse, a.busy, a.done, a.step, e.pulse, e.busy, e.done, e.step);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input int n);
    repeat (n) begin
      @(negedge clk);
      compared++;
      if (btn_pulse !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 3'd0) begin
        mismatched++;
        $display("FAIL reset state @%0t: pulse=%b busy=%b done=%b step=%0d",
                 $time, btn_pulse, busy, done, step_idx);
      end
    end
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL timeout @%0t: done not seen within %0d cycles", $time, limit);
    end
  endtask

  // Start pulse for one cycle; inputs are scrambled afterwards to exercise latching.
  task automatic go(input logic [2:0] len, input logic [11:0] codes);
    @(negedge clk);
    start     = 1'b1;
    seq_len   = len;
    seq_codes = codes;
    @(negedge clk);
    start     = 1'b0;
    seq_len   = 3'($urandom_range(0, 7));
    seq_codes = 12'($urandom);
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] len);
    @(negedge clk);
    start   = 1'b1;
    seq_len = len;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // step3..step0
  localparam logic [11:0] C_BASIC = {3'd0, 3'd4, 3'd0, 3'd2};
  localparam logic [11:0] C_REST  = {3'd0, 3'd4, 3'd7, 3'd2};
  localparam logic [11:0] C_FOUR  = {3'd1, 3'd3, 3'd0, 3'd2};

  initial begin
    int r;
    reset = 1'b1;
    check_idle_outputs(3);
    reset = 1'b0;
    check_idle_outputs(4);

    go(3'd3, C_BASIC);
    wait_done(40);
    idle(5);
    go(3'd3, C_REST);
    wait_done(40);
    idle(5);

    go(3'd3, C_BASIC);
    idle(3);
    pulse_abort();
    idle(20);
    go(3'd3, C_BASIC);
    wait_done(40);
    idle(5);

    go(3'd3, C_BASIC);
    idle(2);
    pulse_start(3'd4);
    idle(22);
    go(3'd0, C_BASIC);
    idle(5);
    go(3'd6, C_FOUR);
    wait_done(40);
    idle(5);

    go(3'd3, C_BASIC);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    go(3'd3, C_BASIC);
    wait_done(40);
    idle(5);

    @(negedge clk);
    start   = 1'b1;
    abort   = 1'b1;
    seq_len = 3'd3;
    @(negedge clk);
    start   = 1'b0;
    abort   = 1'b0;
    idle(3);

    for (int it = 0; it < 40; it++) begin
      go(3'($urandom_range(0, 7)), 12'($urandom));
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        idle(int'($urandom_range(0, 20)));
        pulse_abort();
      end else if (r == 1) begin
        idle(int'($urandom_range(0, 20)));
        pulse_start(3'($urandom_range(1, 7)));
      end else if (r == 2) begin
        idle(int'($urandom_range(0, 20)));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      idle(int'($urandom_range(0, 30)));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
